// File: rtl/dmar_2_axi.sv
// dmar_2_axi: splits one DMA read request into aligned AXI3 INCR read bursts and returns byte-enabled data
module dmar_2_axi #(
  parameter logic [3:0] ARID_VAL = 4'h0,
  parameter int MAX_BT_BYTE = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_dma_halt,
  input  logic        cfg_bf,
  input  logic        cfg_cf,
  input  logic [5:0]  buf_free_word,
  input  logic        dma_r_req,
  output logic        dma_r_ack,
  input  logic [31:0] dma_r_addr,
  input  logic [15:0] dma_r_len,
  output logic        dma_r_dvld,
  output logic [31:0] dma_rdata,
  output logic [3:0]  dma_rbe,
  output logic        dma_r_dlast,
  output logic        dma_r_err,
  output logic        dma_r_done,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_AR, S_R} state_t;
  state_t state, state_nx;
  logic [31:0] cur_addr;
  logic [16:0] rem, rem_nx;
  logic [6:0]  bt_byte, off, win, bt_c, end_sum;
  logic [3:0]  arlen_c, arlen_sel, fbe, lbe, fbe_c, lbe_c;
  logic        first, beat, ar_ok, unused;
  assign arid    = ARID_VAL;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = {2'b00, cfg_cf, cfg_bf};
  assign arprot  = 3'b000;
  assign rready  = state == S_R;
  assign beat    = rready && rvalid;
  assign off     = {1'b0, cur_addr[5:0]} & 7'(MAX_BT_BYTE - 1);
  assign win     = 7'(MAX_BT_BYTE) - off;
  assign bt_c    = (rem < 17'(win)) ? rem[6:0] : win;
  assign end_sum = 7'(cur_addr[1:0]) + bt_c - 7'd1;
  assign arlen_c = end_sum[5:2];
  assign fbe_c   = 4'hF << cur_addr[1:0];
  assign lbe_c   = 4'hF >> (2'd3 - end_sum[1:0]);
  assign rem_nx  = rem - 17'(bt_byte);
  assign arlen_sel = state == S_CALC ? arlen_c : arlen;
  assign ar_ok   = buf_free_word >= 6'(arlen_sel) + 6'd1 && !cfg_dma_halt;
  assign unused  = ^{rid, rresp[0], end_sum[6]};
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= S_IDLE;
    else state <= state_nx;
  // next-state and request acknowledge
  always_comb begin
    state_nx  = state;
    dma_r_ack = 1'b0;
    case (state)
      S_IDLE: if (dma_r_req && !cfg_dma_halt) begin
        dma_r_ack = 1'b1;
        state_nx  = S_CALC;
      end
      S_CALC: state_nx = S_AR;
      S_AR:   if (arvalid && arready) state_nx = S_R;
      S_R:    if (rvalid && rlast) state_nx = rem_nx == 17'd0 ? S_IDLE : S_CALC;
      default: state_nx = S_IDLE;
    endcase
  end
  // burst planning, AR channel and read-data return path
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cur_addr    <= '0;
      rem         <= '0;
      bt_byte     <= '0;
      araddr      <= '0;
      arlen       <= '0;
      fbe         <= '0;
      lbe         <= '0;
      first       <= 1'b0;
      arvalid     <= 1'b0;
      dma_r_dvld  <= 1'b0;
      dma_rdata   <= '0;
      dma_rbe     <= '0;
      dma_r_err   <= 1'b0;
      dma_r_dlast <= 1'b0;
      dma_r_done  <= 1'b0;
    end else begin
      if (dma_r_ack) begin
        cur_addr <= dma_r_addr;
        rem      <= {1'b0, dma_r_len} + 17'd1;
      end
      if (state == S_CALC) begin
        bt_byte <= bt_c;
        araddr  <= {cur_addr[31:2], 2'b00};
        arlen   <= arlen_c;
        fbe     <= fbe_c;
        lbe     <= lbe_c;
        first   <= 1'b1;
      end
      arvalid     <= state == S_CALC ? ar_ok : state == S_AR ? (arvalid ? !arready : ar_ok) : 1'b0;
      dma_r_dvld  <= beat;
      dma_r_err   <= beat && rresp[1];
      dma_r_dlast <= beat && rlast && rem_nx == 17'd0;
      dma_r_done  <= dma_r_dlast;
      if (beat) begin
        dma_rdata <= rdata;
        dma_rbe   <= first && rlast ? fbe & lbe : first ? fbe : rlast ? lbe : 4'hF;
        first     <= 1'b0;
      end
      if (beat && rlast) begin
        cur_addr <= cur_addr + 32'(bt_byte);
        rem      <= rem_nx;
      end
    end
endmodule

// File: tb/tb_dmar_2_axi.sv
// tb_dmar_2_axi: directed bench for the DMA read to AXI3 burst splitter
module tb_dmar_2_axi;
  logic clk = 1'b0, rstn = 1'b0;
  logic cfg_dma_halt = 1'b0, cfg_bf = 1'b1, cfg_cf = 1'b0;
  logic [5:0] buf_free_word = 6'd32;
  logic dma_r_req = 1'b0, dma_r_ack;
  logic [31:0] dma_r_addr = '0;
  logic [15:0] dma_r_len = '0;
  logic dma_r_dvld, dma_r_dlast, dma_r_err, dma_r_done;
  logic [31:0] dma_rdata, araddr;
  logic [3:0] dma_rbe, arid, arlen, arcache;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  logic arvalid, arready = 1'b0, rready;
  logic [3:0] rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rlast = 1'b0, rvalid = 1'b0;
  int n_chk = 0, n_fail = 0;

  dmar_2_axi dut (
    .clk(clk), .rstn(rstn), .cfg_dma_halt(cfg_dma_halt), .cfg_bf(cfg_bf), .cfg_cf(cfg_cf),
    .buf_free_word(buf_free_word), .dma_r_req(dma_r_req), .dma_r_ack(dma_r_ack),
    .dma_r_addr(dma_r_addr), .dma_r_len(dma_r_len), .dma_r_dvld(dma_r_dvld),
    .dma_rdata(dma_rdata), .dma_rbe(dma_rbe), .dma_r_dlast(dma_r_dlast), .dma_r_err(dma_r_err),
    .dma_r_done(dma_r_done), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] l);
    dma_r_addr = a;
    dma_r_len  = l;
    dma_r_req  = 1'b1;
    #1 chk("ack", dma_r_ack, 1);
    tick;
    dma_r_req = 1'b0;
    #1 chk("ack_pulse", dma_r_ack, 0);
  endtask

  task automatic burst(input logic [31:0] ea, input logic [3:0] el, input logic [3:0] fb,
                       input logic [3:0] lb, input logic last, input int eb);
    int n = 0;
    while (!arvalid && n < 50) begin
      tick;
      n++;
    end
    chk("arvalid_up", arvalid, 1);
    chk("araddr", araddr, ea);
    chk("arlen", 32'(arlen), 32'(el));
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("arvalid_down", arvalid, 0);
    chk("rready", rready, 1);
    for (int b = 0; b <= int'(el); b++) begin
      rvalid = 1'b1;
      rdata  = ea ^ 32'(b);
      rlast  = b == int'(el);
      rresp  = b == eb ? 2'b10 : 2'b00;
      tick;
      chk("dvld", dma_r_dvld, 1);
      chk("rdata", dma_rdata, ea ^ 32'(b));
      chk("rbe", 32'(dma_rbe), 32'(el == 0 ? fb & lb : b == 0 ? fb : b == int'(el) ? lb : 4'hF));
      chk("err", dma_r_err, 32'(b == eb));
      chk("dlast", dma_r_dlast, 32'(last && b == int'(el)));
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    tick;
    chk("dvld_idle", dma_r_dvld, 0);
    chk("done", dma_r_done, 32'(last));
  endtask

  initial begin
    repeat (2) tick;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_ack", dma_r_ack, 0);
    chk("rst_dvld", dma_r_dvld, 0);
    chk("rst_done", dma_r_done, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", 32'(arlen), 0);
    rstn = 1'b1;
    tick;
    start(32'h1000_0002, 16'd8);
    tick;
    chk("latency_arvalid", arvalid, 1);
    chk("arsize", 32'(arsize), 2);
    chk("arburst", 32'(arburst), 1);
    chk("arcache", 32'(arcache), 1);
    chk("arid", 32'(arid), 0);
    burst(32'h1000_0000, 4'd2, 4'b1100, 4'b0111, 1'b1, -1);
    start(32'h0000_0FF0, 16'h2F);
    burst(32'h0000_0FF0, 4'd3, 4'hF, 4'hF, 1'b0, -1);
    burst(32'h0000_1000, 4'd7, 4'hF, 4'hF, 1'b1, -1);
    start(32'h2000_0000, 16'hFF);
    for (int k = 0; k < 4; k++)
      burst(32'h2000_0000 + 32'(64 * k), 4'd15, 4'hF, 4'hF, k == 3, -1);
    buf_free_word = 6'd10;
    start(32'h3000_0000, 16'd63);
    tick;
    chk("nospace_arvalid0", arvalid, 0);
    tick;
    chk("nospace_arvalid1", arvalid, 0);
    buf_free_word = 6'd16;
    tick;
    chk("space_arvalid", arvalid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_arvalid", arvalid, 1);
      chk("hold_araddr", araddr, 32'h3000_0000);
      chk("hold_arlen", 32'(arlen), 15);
    end
    burst(32'h3000_0000, 4'd15, 4'hF, 4'hF, 1'b1, -1);
    buf_free_word = 6'd32;
    cfg_dma_halt = 1'b1;
    dma_r_addr = 32'h4000_0000;
    dma_r_len = 16'd127;
    dma_r_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_noack", dma_r_ack, 0);
      tick;
    end
    cfg_dma_halt = 1'b0;
    start(32'h4000_0000, 16'd127);
    tick;
    cfg_dma_halt = 1'b1;
    burst(32'h4000_0000, 4'd15, 4'hF, 4'hF, 1'b0, -1);
    chk("halt_withheld0", arvalid, 0);
    repeat (2) tick;
    chk("halt_withheld1", arvalid, 0);
    cfg_dma_halt = 1'b0;
    tick;
    chk("halt_release", arvalid, 1);
    burst(32'h4000_0040, 4'd15, 4'hF, 4'hF, 1'b1, -1);
    start(32'h5000_0000, 16'd15);
    burst(32'h5000_0000, 4'd3, 4'hF, 4'hF, 1'b1, 1);
    start(32'h6000_0000, 16'd15);
    tick;
    chk("rst_case_arvalid", arvalid, 1);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h1234_5678;
    tick;
    rvalid = 1'b0;
    chk("pre_rst_dvld", dma_r_dvld, 1);
    chk("pre_rst_rready", rready, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_rready", rready, 0);
    chk("async_rst_dvld", dma_r_dvld, 0);
    chk("async_rst_arvalid", arvalid, 0);
    tick;
    rstn = 1'b1;
    tick;
    chk("post_rst_rready", rready, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
